ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Multi-cycle RV32M execute unit, used next to the single-cycle ALU in the EX stage.
//  Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU as iterative shift-add and restoring-divide loops.
//  Raises hold_flag_o to ctrl so the pipeline stalls while an operation is in flight.
//  Writes rd through the normal register write port for exactly one cycle per operation.
// PARAMETERS
//  XLEN            32  operand/result width; must be a multiple of BITS_PER_CYCLE
//  BITS_PER_CYCLE  1   bits processed per CALC cycle; legal values 1, 2, 4
// PORTS
//  clk          in   1     clock; all state updates on rising edge
//  rst_n        in   1     synchronous reset, active low
//  start_i      in   1     EX holds a RV32M instruction (opcode R_M, func7 = 0000001)
//  op_i         in   3     func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  op1_i        in   XLEN  rs1 value
//  op2_i        in   XLEN  rs2 value
//  rd_addr_i    in   5     destination register
//  flush_i      in   1     jump/flush from ctrl; kills any pending operation
//  rd_addr_o    out  5     latched destination register
//  rd_data_o    out  XLEN  result; valid only while reg_wen_o = 1
//  reg_wen_o    out  1     one-cycle write strobe
//  hold_flag_o  out  1     stall request to ctrl
// BEHAVIOUR
//  Reset (rst_n = 0 at a clk edge):
//   - state goes to IDLE; counter and all datapath registers go to 0.
//   - rd_addr_o = 0, rd_data_o = 0, reg_wen_o = 0, hold_flag_o = 0.
//   - Reset wins over every other input, including during CALC or DONE.
//  FSM states: IDLE, CALC, DONE. Define N = XLEN/BITS_PER_CYCLE.
//  IDLE:
//   - start_i=1 and flush_i=0: latch op_i, rd_addr_i and the operand magnitudes.
//   - Signed ops (MULH, DIV, REM) take the magnitude of both operands; MULHSU takes the magnitude of op1 only.
//   - Latch the result sign bit(s) and set counter = 0.
//   - Next state is DONE for a special case, otherwise CALC.
//  Special cases:
//   - Divisor 0: quotient = all ones; remainder = op1.
//   - DIV/REM with op1 = 2^(XLEN-1) and op2 = all ones: quotient = op1; remainder = 0.
//  CALC:
//   - Each cycle retires BITS_PER_CYCLE multiplier bits (shift-add into a 2*XLEN accumulator)
//     or BITS_PER_CYCLE quotient bits (restoring divide).
//   - counter increments by 1; when counter = N-1, next state is DONE.
//  DONE:
//   - Apply sign fix: negate the 2*XLEN product if the result sign is negative.
//   - Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1). Skip the fix for special cases.
//   - Select result: MUL = product[XLEN-1:0]; MULH* = product[2XLEN-1:XLEN]; DIV* = quotient; REM* = remainder.
//   - reg_wen_o = 1 for this cycle only. Next state is IDLE.
//  Latency:
//   - Normal ops: start seen in cycle 0 -> reg_wen_o in cycle N+1 (33 for XLEN=32, BPC=1).
//   - Special cases: reg_wen_o in cycle 1.
//  hold_flag_o (combinational) = (IDLE & start_i & ~flush_i) | CALC.
//   - It is low in DONE, so the pipeline advances in the same cycle as writeback.
//  Flush rules:
//   - flush_i in CALC or DONE: next state IDLE; reg_wen_o forced 0 that cycle; no write occurs.
//   - flush_i in IDLE: start_i is ignored.
//  start_i outside IDLE is ignored. It cannot legally occur, because EX is held.
//  reg_wen_o, rd_addr_o and rd_data_o are driven from DONE-state registers and combinational select.
//  Outside DONE they are 0.
//  All arithmetic is modulo 2^XLEN, with no overflow trap, per the RISC-V M spec.
// TESTING
//  1. MUL 7 * 0xFFFFFFFD -> rd_data_o = 0xFFFFFFEB; reg_wen_o only in cycle 33; hold_flag_o high for cycles 0-32.
//  2. MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF;
//     MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//  3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
//  4. DIVU 0x1234 / 0 -> 0xFFFFFFFF and REMU -> 0x1234, both with reg_wen_o in cycle 1;
//     DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0.
//  5. flush_i pulsed in CALC cycle 10 -> state IDLE next cycle; no reg_wen_o pulse;
//     a new start_i is accepted the following cycle.
//  6. rst_n low in CALC cycle 5 -> every output 0 on the next edge; after release, MUL 3 * 5 -> 15.
//     Repeat tests 1-4 with BITS_PER_CYCLE = 4: latency 9 cycles, results identical.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide.
// Stalls the pipeline while busy and writes rd for one cycle in DONE.
module ex_muldiv #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            reg_wen_o,
    output logic            hold_flag_o
);
    localparam int unsigned N    = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // mul: running product; div: {partial remainder, dividend shifting into quotient}
    logic [2*XLEN-1:0] acc_q, acc_d;
    // mul: multiplicand shifted left each bit; div: divisor in the low half
    logic [2*XLEN-1:0] a_q, a_d;
    // mul: multiplier shifted right each bit
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;         // product / quotient sign
    logic              rem_neg_q, rem_neg_d; // remainder sign
    logic              special_q, special_d; // result already final, skip sign fix

    logic              is_div, op1_signed, op2_signed, s1, s2, div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2;
    logic [2*XLEN-1:0] step_acc, step_a;
    logic [XLEN-1:0]   step_b;
    logic [XLEN:0]     rem_sh;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, result;

    // Operand decode: magnitudes, signs and divide special cases
    always_comb begin
        is_div     = op_i[2];
        op1_signed = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
        op2_signed = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        s1         = op1_signed & op1_i[XLEN-1];
        s2         = op2_signed & op2_i[XLEN-1];
        mag1       = s1 ? -op1_i : op1_i;
        mag2       = s2 ? -op2_i : op2_i;
        div_zero   = is_div && (op2_i == '0);
        div_ovf    = is_div && !op_i[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    end

    // One CALC step: BITS_PER_CYCLE multiplier bits or quotient bits
    always_comb begin
        step_acc = acc_q;
        step_a   = a_q;
        step_b   = b_q;
        rem_sh   = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (!op_q[2]) begin
                if (step_b[0]) begin
                    step_acc = step_acc + step_a;
                end
                step_a = step_a << 1;
                step_b = step_b >> 1;
            end else begin
                rem_sh = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
                if (rem_sh >= {1'b0, step_a[XLEN-1:0]}) begin
                    rem_sh   = rem_sh - {1'b0, step_a[XLEN-1:0]};
                    step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
                end else begin
                    step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    // Next-state and datapath load/update
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        special_d = special_q;
        case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    op_d      = op_i;
                    rd_addr_d = rd_addr_i;
                    cnt_d     = '0;
                    neg_d     = s1 ^ s2;
                    rem_neg_d = s1;
                    special_d = div_zero || div_ovf;
                    a_d       = '0;
                    b_d       = '0;
                    if (div_zero) begin
                        acc_d   = {op1_i, {XLEN{1'b1}}};
                        state_d = StDone;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, op1_i};
                        state_d = StDone;
                    end else if (is_div) begin
                        acc_d   = {{XLEN{1'b0}}, mag1};
                        a_d     = {{XLEN{1'b0}}, mag2};
                        state_d = StCalc;
                    end else begin
                        acc_d   = '0;
                        a_d     = {{XLEN{1'b0}}, mag1};
                        b_d     = mag2;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step_acc;
                    a_d   = step_a;
                    b_d   = step_b;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(N - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sign fix and result select
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quot = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        if (!special_q) begin
            if (neg_q) quot = -quot;
            if (rem_neg_q) rem = -rem;
        end
        case (op_q)
            3'b000:                 result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = quot;
            default:                result = rem;
        endcase
    end

    // Writeback only in DONE, suppressed by a flush in that same cycle
    always_comb begin
        reg_wen_o   = (state_q == StDone) && !flush_i;
        rd_addr_o   = reg_wen_o ? rd_addr_q : '0;
        rd_data_o   = reg_wen_o ? result : '0;
        hold_flag_o = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StCalc);
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            special_q <= special_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: one DUT at 1 bit/cycle and one at 4 bits/cycle share stimulus.
module tb_ex_muldiv;
    logic        clk;
    logic        rst_n, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic [4:0]  rd_addr1, rd_addr4;
    logic [31:0] rd_data1, rd_data4;
    logic        wen1, wen4, hold1, hold4;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .op1_i(op1_i),
        .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i), .rd_addr_o(rd_addr1),
        .rd_data_o(rd_data1), .reg_wen_o(wen1), .hold_flag_o(hold1)
    );

    ex_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .op1_i(op1_i),
        .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i), .rd_addr_o(rd_addr4),
        .rd_data_o(rd_data4), .reg_wen_o(wen4), .hold_flag_o(hold4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation in the current cycle and watch both DUTs for 40 cycles
    task automatic run_op(input int idx, input vec_t v);
        int          lat1, lat4, cnt1, cnt4, herr1, herr4, zerr;
        int          exp1, exp4;
        logic [31:0] d1, d4;
        logic [4:0]  a1, a4, rd;
        lat1 = -1; lat4 = -1; cnt1 = 0; cnt4 = 0; herr1 = 0; herr4 = 0; zerr = 0;
        d1 = '0; d4 = '0; a1 = '0; a4 = '0;
        exp1 = v.special ? 1 : 33;
        exp4 = v.special ? 1 : 9;
        rd = 5'(idx + 1);
        op_i = v.op; op1_i = v.a; op2_i = v.b; rd_addr_i = rd; start_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (wen1) begin
                cnt1++;
                if (lat1 < 0) begin lat1 = c; d1 = rd_data1; a1 = rd_addr1; end
            end else if (rd_data1 != '0 || rd_addr1 != '0) begin
                zerr++;
            end
            if (wen4) begin
                cnt4++;
                if (lat4 < 0) begin lat4 = c; d4 = rd_data4; a4 = rd_addr4; end
            end else if (rd_data4 != '0 || rd_addr4 != '0) begin
                zerr++;
            end
            if (hold1 !== (c < exp1)) herr1++;
            if (hold4 !== (c < exp4)) herr4++;
            tick();
            start_i = 1'b0;
        end
        check($sformatf("v%0d data bpc1", idx), d1, v.exp);
        check($sformatf("v%0d data bpc4", idx), d4, v.exp);
        check($sformatf("v%0d latency bpc1", idx), 32'(lat1), 32'(exp1));
        check($sformatf("v%0d latency bpc4", idx), 32'(lat4), 32'(exp4));
        check($sformatf("v%0d wen pulses bpc1", idx), 32'(cnt1), 32'd1);
        check($sformatf("v%0d wen pulses bpc4", idx), 32'(cnt4), 32'd1);
        check($sformatf("v%0d rd_addr bpc1", idx), {27'd0, a1}, {27'd0, rd});
        check($sformatf("v%0d rd_addr bpc4", idx), {27'd0, a4}, {27'd0, rd});
        check($sformatf("v%0d hold errors bpc1", idx), 32'(herr1), 32'd0);
        check($sformatf("v%0d hold errors bpc4", idx), 32'(herr4), 32'd0);
        check($sformatf("v%0d outputs nonzero outside write", idx), 32'(zerr), 32'd0);
    endtask

    // MUL 7*-3 with a flush and/or reset at chosen cycles; snapshot outputs at snap_at.
    // snap = {wen1, wen4, hold1, hold4, data1!=0, data4!=0, addr1!=0, addr4!=0}
    task automatic run_seq(input string name, input int len, input int flush_at,
                           input int rst_at, input int snap_at, input logic [7:0] exp_snap,
                           input int exp_cnt1, input int exp_cnt4);
        int         cnt1, cnt4;
        logic [7:0] snap;
        cnt1 = 0; cnt4 = 0; snap = 8'hxx;
        op_i = 3'b000; op1_i = 32'd7; op2_i = 32'hFFFF_FFFD; rd_addr_i = 5'd9; start_i = 1'b1;
        for (int c = 0; c < len; c++) begin
            flush_i = (c == flush_at);
            rst_n   = (c != rst_at);
            #1;
            if (wen1) cnt1++;
            if (wen4) cnt4++;
            if (c == snap_at) begin
                snap = {wen1, wen4, hold1, hold4, rd_data1 != '0, rd_data4 != '0,
                        rd_addr1 != '0, rd_addr4 != '0};
            end
            tick();
            start_i = 1'b0;
        end
        flush_i = 1'b0;
        rst_n   = 1'b1;
        check({name, " snapshot"}, {24'd0, snap}, {24'd0, exp_snap});
        check({name, " wen pulses bpc1"}, 32'(cnt1), 32'(exp_cnt1));
        check({name, " wen pulses bpc4"}, 32'(cnt4), 32'(exp_cnt4));
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0}; // MUL
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0}; // MULH
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0}; // MULHSU
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0}; // MULHU
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0}; // DIV
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0}; // REM
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        1'b0}; // DIVU
        vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         1'b0}; // REMU
        vecs[8]  = '{3'b101, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b1}; // DIVU /0
        vecs[9]  = '{3'b111, 32'h0000_1234,  32'd0,         32'h0000_1234, 1'b1}; // REMU /0
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1}; // DIV ovf
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1}; // REM ovf
        vecs[12] = '{3'b100, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0}; // 100/-7
        vecs[13] = '{3'b110, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 1'b0}; // -100%7
        vecs[14] = '{3'b001, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0}; // MULH -1*1
        vecs[15] = '{3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b1}; // DIV /0
        vecs[16] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1}; // REM /0
        vecs[17] = '{3'b000, 32'd3,          32'd5,         32'd15,        1'b0}; // MUL
        vecs[18] = '{3'b010, 32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 1'b0}; // MULHSU
        vecs[19] = '{3'b101, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 1'b0}; // DIVU

        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
        op1_i = '0; op2_i = '0; rd_addr_i = '0;
        tick();
        tick();
        check("reset outputs bpc1", {rd_data1}, 32'd0);
        check("reset outputs bpc4", {rd_data4}, 32'd0);
        check("reset ctrl", {24'd0, wen1, wen4, hold1, hold4, 4'd0}, 32'd0);
        check("reset rd_addr", {22'd0, rd_addr1, rd_addr4}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_op(i, vecs[i]);
        end

        // Flush in CALC cycle 10: bpc1 killed, bpc4 already wrote in cycle 9;
        // cycle 11 is idle, then a new start is taken straight away
        run_seq("flush calc", 12, 10, -1, 11, 8'h00, 0, 1);
        run_op(17, vecs[17]);
        // Flush in cycle 9: bpc4 DONE suppressed, bpc1 still holding in CALC at that moment
        run_seq("flush done bpc4", 40, 9, -1, 9, 8'b0010_0000, 0, 0);
        run_op(0, vecs[0]);
        // Flush in cycle 33: bpc1 DONE suppressed
        run_seq("flush done bpc1", 40, 33, -1, 33, 8'h00, 0, 1);
        // Flush together with start in IDLE: start ignored
        run_seq("flush idle", 40, 0, -1, 0, 8'h00, 0, 0);
        // Reset in CALC cycle 5: all outputs zero next cycle, nothing written
        run_seq("reset calc", 40, -1, 5, 6, 8'h00, 0, 0);
        run_op(17, vecs[17]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
